// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that lets NUM_REQ byte producers share one UART TX serializer.
// It accepts one byte per frame, holds it for the whole frame and paces the frame with baud strobes and a FINISH pulse.
module uart_tx_sched #(
  parameter int NUM_REQ       = 4,
  parameter int CLKS_PER_BAUD = 434,
  parameter int CNT_W         = 9,
  parameter int ID_W          = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   iREQ_VALID,
  input  logic [8*NUM_REQ-1:0] iREQ_DATA,
  output logic [NUM_REQ-1:0]   oREQ_READY,
  output logic                 oTX_BAUD_clk,
  output logic [7:0]           oTX_FIFO_DATA,
  output logic                 oFINISH,
  output logic                 oBUSY,
  output logic [ID_W-1:0]      oGRANT_ID
);

  typedef enum logic [1:0] {IDLE, SEND, STOP, FIN} state_t;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BAUD - 1);
  // STOP starts one cycle after the last strobe, so it ends one count early.
  // That puts FINISH exactly 11 bit periods after the grant.
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BAUD - 2);
  localparam logic [3:0]       LAST_BIT  = 4'd9;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  baudCnt, baudCntNext;
  logic [3:0]        bitCnt, bitCntNext;
  logic [ID_W-1:0]   rrPtr;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              grantNow;

  // Search upward from the previous winner so that it gets the lowest priority.
  // NOTE: always_comb uses blocking '=' and assigns every output a default first, so no latch can be inferred.
  always_comb begin
    found  = 1'b0;
    winner = rrPtr;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!found && iREQ_VALID[(int'(rrPtr) + off) % NUM_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(rrPtr) + off) % NUM_REQ);
      end
    end
  end

  always_comb begin
    stateNext    = state;
    baudCntNext  = baudCnt;
    bitCntNext   = bitCnt;
    grantNow     = 1'b0;
    oTX_BAUD_clk = 1'b0;
    oFINISH      = 1'b0;
    oREQ_READY   = '0;
    unique case (state)
      IDLE: begin
        if (found && !reset) begin
          grantNow           = 1'b1;
          oREQ_READY[winner] = 1'b1;
          stateNext          = SEND;
          baudCntNext        = '0;
          bitCntNext         = '0;
        end
      end
      SEND: begin
        if (baudCnt == BAUD_LAST) begin
          oTX_BAUD_clk = 1'b1;
          baudCntNext  = '0;
          bitCntNext   = bitCnt + 4'd1;
          if (bitCnt == LAST_BIT) stateNext = STOP;
        end else begin
          baudCntNext = baudCnt + 1'b1;
        end
      end
      STOP: begin
        if (baudCnt == STOP_LAST) begin
          baudCntNext = '0;
          stateNext   = FIN;
        end else begin
          baudCntNext = baudCnt + 1'b1;
        end
      end
      FIN: begin
        oFINISH   = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign oBUSY = (state != IDLE);

  // NOTE: sequential state uses non-blocking '<=' so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      baudCnt       <= '0;
      bitCnt        <= '0;
      rrPtr         <= ID_W'(NUM_REQ - 1);
      oTX_FIFO_DATA <= 8'h00;
      oGRANT_ID     <= '0;
    end else begin
      state   <= stateNext;
      baudCnt <= baudCntNext;
      bitCnt  <= bitCntNext;
      if (grantNow) begin
        oTX_FIFO_DATA <= iREQ_DATA[int'(winner)*8 +: 8];
        rrPtr         <= winner;
        oGRANT_ID     <= winner;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: one instance with a 4-cycle bit period and one with a 2-cycle bit period.
// Negedge monitors record grants, strobes and finishes, and decode the serial frame.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic [3:0]  v4, r4, v2, r2;
  logic [31:0] d4, d2;
  logic        b4, f4, bz4, b2, f2, bz2;
  logic [7:0]  td4, td2;
  logic [1:0]  gi4, gi2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_sched #(.NUM_REQ(4), .CLKS_PER_BAUD(4), .CNT_W(3), .ID_W(2)) dut4 (
    .clk(clk), .reset(reset), .iREQ_VALID(v4), .iREQ_DATA(d4), .oREQ_READY(r4),
    .oTX_BAUD_clk(b4), .oTX_FIFO_DATA(td4), .oFINISH(f4), .oBUSY(bz4), .oGRANT_ID(gi4));

  uart_tx_sched #(.NUM_REQ(4), .CLKS_PER_BAUD(2), .CNT_W(2), .ID_W(2)) dut2 (
    .clk(clk), .reset(reset), .iREQ_VALID(v2), .iREQ_DATA(d2), .oREQ_READY(r2),
    .oTX_BAUD_clk(b2), .oTX_FIFO_DATA(td2), .oFINISH(f2), .oBUSY(bz2), .oGRANT_ID(gi2));

  // Event records and the serial-line model for each instance.
  int         gcyc4[$], strb4[$], fin4[$];
  logic [3:0] gvec4[$];
  logic [7:0] fdat4[$];
  logic [1:0] fid4[$];
  logic [9:0] dec4;
  int         bidx4 = 0;

  int         gcyc2[$], strb2[$], fin2[$];
  logic [9:0] dec2;
  int         bidx2 = 0;
  int         dbl2 = 0;
  logic       prevB2 = 1'b0;

  function automatic logic line_bit(input int idx, input logic [7:0] data);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return data[idx-1];
    else return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      bidx4 = 0;
    end else begin
      if (r4 != 4'b0) begin
        gcyc4.push_back(cyc);
        gvec4.push_back(r4);
        bidx4 = 0;
        dec4  = '0;
      end
      if (b4) begin
        strb4.push_back(cyc);
        if (bidx4 < 10) dec4[bidx4] = line_bit(bidx4, td4);
        bidx4++;
      end
      if (f4) begin
        fin4.push_back(cyc);
        fdat4.push_back(td4);
        fid4.push_back(gi4);
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      bidx2  = 0;
      prevB2 = 1'b0;
    end else begin
      if (r2 != 4'b0) begin
        gcyc2.push_back(cyc);
        bidx2 = 0;
        dec2  = '0;
      end
      if (b2) begin
        strb2.push_back(cyc);
        if (prevB2) dbl2++;
        if (bidx2 < 10) dec2[bidx2] = line_bit(bidx2, td2);
        bidx2++;
      end
      if (f2) fin2.push_back(cyc);
      prevB2 = b2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fin4(input int n, input int budget, input string name);
    while (fin4.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    check(name, 32'(fin4.size() >= n), 32'd1);
  endtask

  task automatic clear4();
    gcyc4.delete(); strb4.delete(); fin4.delete();
    gvec4.delete(); fdat4.delete(); fid4.delete();
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
  } arb_vec_t;

  arb_vec_t tabPtr3[6];
  arb_vec_t tabPtr2[4];

  task automatic apply_table(input arb_vec_t vec, input string name);
    v4 = vec.valid;
    #1;
    check(name, 32'(r4), 32'(vec.ready));
    v4 = 4'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ord[5];
    int budget;

    // Arbitration right after reset (pointer at 3), then after requester 2 has won.
    tabPtr3[0] = '{4'b0001, 4'b0001};
    tabPtr3[1] = '{4'b0110, 4'b0010};
    tabPtr3[2] = '{4'b1000, 4'b1000};
    tabPtr3[3] = '{4'b1100, 4'b0100};
    tabPtr3[4] = '{4'b1111, 4'b0001};
    tabPtr3[5] = '{4'b0000, 4'b0000};
    tabPtr2[0] = '{4'b1111, 4'b1000};
    tabPtr2[1] = '{4'b0011, 4'b0001};
    tabPtr2[2] = '{4'b0100, 4'b0100};
    tabPtr2[3] = '{4'b0101, 4'b0001};
    ord = '{0, 1, 2, 3, 0};

    reset = 1'b1; v4 = '0; d4 = '0; v2 = '0; d2 = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_ready", 32'(r4), 32'd0);
    check("rst_baud", 32'(b4), 32'd0);
    check("rst_finish", 32'(f4), 32'd0);
    check("rst_busy", 32'(bz4), 32'd0);
    check("rst_data", 32'(td4), 32'h00);
    check("rst_grant_id", 32'(gi4), 32'd0);

    foreach (tabPtr3[i]) apply_table(tabPtr3[i], $sformatf("arb_ptr3_%0d", i));

    // Single byte from requester 2.
    clear4();
    v4 = 4'b0100;
    d4[23:16] = 8'hA5;
    #1;
    check("single_ready", 32'(r4), 32'b0100);
    tick();
    v4 = 4'b0;
    check("single_data", 32'(td4), 32'hA5);
    check("single_id", 32'(gi4), 32'd2);
    check("single_busy", 32'(bz4), 32'd1);
    wait_fin4(1, 60, "single_fin_timeout");
    check("single_strobe_count", 32'(strb4.size()), 32'd10);
    for (int k = 0; k < 10; k++)
      check($sformatf("single_strobe_%0d", k), 32'(strb4[k] - gcyc4[0]), 32'(4 * (k + 1)));
    check("single_fin_time", 32'(fin4[0] - gcyc4[0]), 32'd44);
    check("single_line_bits", 32'(dec4), 32'(10'b1101001010));
    check("single_busy_after", 32'(bz4), 32'd0);
    check("single_grants", 32'(gvec4.size()), 32'd1);

    foreach (tabPtr2[i]) apply_table(tabPtr2[i], $sformatf("arb_ptr2_%0d", i));

    // Round-robin with every requester valid.
    reset = 1'b1; tick(); reset = 1'b0;
    clear4();
    d4 = {8'h13, 8'h12, 8'h11, 8'h10};
    v4 = 4'b1111;
    budget = 300;
    while (gvec4.size() < 5 && budget > 0) begin
      tick();
      budget--;
    end
    v4 = 4'b0;
    check("rr_grant_timeout", 32'(gvec4.size() >= 5), 32'd1);
    wait_fin4(5, 100, "rr_fin_timeout");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_ready_%0d", i), 32'(gvec4[i]), 32'(4'b0001 << ord[i]));
      check($sformatf("rr_id_%0d", i), 32'(fid4[i]), 32'(ord[i]));
      check($sformatf("rr_byte_%0d", i), 32'(fdat4[i]), 32'(8'h10 + ord[i]));
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_gap_%0d", i), 32'(gcyc4[i+1] - gcyc4[i]), 32'd45);

    // Requester 1 raises valid mid-frame and withdraws it before the frame ends.
    clear4();
    d4[23:16] = 8'h77;
    v4 = 4'b0100;
    tick();
    v4 = 4'b0;
    repeat (10) tick();
    v4 = 4'b0010;
    repeat (20) tick();
    v4 = 4'b0;
    wait_fin4(1, 60, "wd_fin_timeout");
    repeat (5) tick();
    check("wd_grants", 32'(gvec4.size()), 32'd1);
    check("wd_first_ready", 32'(gvec4[0]), 32'b0100);
    check("wd_fins", 32'(fin4.size()), 32'd1);
    check("wd_busy_after", 32'(bz4), 32'd0);

    // Reset asserted after the fifth strobe.
    clear4();
    d4[7:0] = 8'hC3;
    v4 = 4'b0001;
    tick();
    v4 = 4'b0;
    budget = 40;
    while (strb4.size() < 5 && budget > 0) begin
      tick();
      budget--;
    end
    check("mid_rst_strobe_timeout", 32'(strb4.size() >= 5), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_ready", 32'(r4), 32'd0);
    check("mid_rst_baud", 32'(b4), 32'd0);
    check("mid_rst_finish", 32'(f4), 32'd0);
    check("mid_rst_busy", 32'(bz4), 32'd0);
    check("mid_rst_data", 32'(td4), 32'h00);
    check("mid_rst_id", 32'(gi4), 32'd0);
    reset = 1'b0;
    repeat (60) tick();
    check("mid_rst_no_finish", 32'(fin4.size()), 32'd0);
    v4 = 4'b1111;
    #1;
    check("mid_rst_first_ready", 32'(r4), 32'b0001);
    tick();
    v4 = 4'b0;
    check("mid_rst_first_id", 32'(gi4), 32'd0);
    wait_fin4(1, 60, "mid_rst_fin_timeout");

    // Requester 3 asks in the very cycle the FSM returns to IDLE.
    clear4();
    d4[15:8] = 8'h55;
    v4 = 4'b0010;
    tick();
    v4 = 4'b0;
    wait_fin4(1, 60, "ret_fin_timeout");
    d4[31:24] = 8'h3C;
    v4 = 4'b1000;
    #1;
    check("ret_ready", 32'(r4), 32'b1000);
    check("ret_data_held", 32'(td4), 32'h55);
    tick();
    v4 = 4'b0;
    check("ret_data_new", 32'(td4), 32'h3C);
    check("ret_id", 32'(gi4), 32'd3);
    check("ret_grant_time", 32'(gcyc4[1] - fin4[0]), 32'd1);
    wait_fin4(2, 60, "ret_fin2_timeout");

    // Minimum divisor instance.
    v2 = 4'b0001;
    d2[7:0] = 8'hFF;
    #1;
    check("min_ready", 32'(r2), 32'b0001);
    tick();
    v2 = 4'b0;
    budget = 40;
    while (fin2.size() < 1 && budget > 0) begin
      tick();
      budget--;
    end
    check("min_fin_timeout", 32'(fin2.size() >= 1), 32'd1);
    check("min_strobe_count", 32'(strb2.size()), 32'd10);
    for (int k = 0; k < 10; k++)
      check($sformatf("min_strobe_%0d", k), 32'(strb2[k] - gcyc2[0]), 32'(2 * (k + 1)));
    check("min_fin_time", 32'(fin2[0] - gcyc2[0]), 32'd22);
    check("min_no_double", 32'(dbl2), 32'd0);
    check("min_line_bits", 32'(dec2), 32'(10'b1111111110));
    check("min_busy_after", 32'(bz2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers.
- Accepts one byte per frame through a valid/ready handshake and holds it on the transmitter's data input for the whole frame.
- Generates the transmitter's baud-strobe pulses and the end-of-frame FINISH pulse.
- Sits between the per-source command/response logic and the UART TX serializer. The frame is start + 8 data bits (LSB first) + stop.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CLKS_PER_BAUD, 434, clk cycles per bit period (50 MHz / 115200); minimum 2
CNT_W, 9, width of the baud counter; must satisfy 2^CNT_W >= CLKS_PER_BAUD
ID_W, 2, width of oGRANT_ID; must satisfy 2^ID_W >= NUM_REQ

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
iREQ_VALID  input  NUM_REQ  per-requester byte valid
iREQ_DATA  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
oREQ_READY  output  NUM_REQ  one-hot, one-cycle accept strobe
oTX_BAUD_clk  output  1  one-cycle baud strobe to the TX serializer
oTX_FIFO_DATA  output  8  byte being transmitted
oFINISH  output  1  one-cycle end-of-frame pulse to the TX serializer
oBUSY  output  1  high from grant until oFINISH, inclusive
oGRANT_ID  output  ID_W  index of the current or last granted requester

Behaviour:
- The module uses the single clock clk. reset is synchronous and active-high.
- Reset values: state=IDLE, oREQ_READY=0, oTX_BAUD_clk=0, oFINISH=0, oBUSY=0, oTX_FIFO_DATA=8'h00, oGRANT_ID=0, baud_cnt=0, bit_cnt=0, rr_ptr=NUM_REQ-1 (so requester 0 has first priority).
- States: IDLE, SEND, STOP, FIN.
- IDLE:
  - If any iREQ_VALID is high, pick the first valid index searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - oREQ_READY is combinational in IDLE: the winner's bit is high in that same cycle, giving a one-cycle transfer.
  - At that edge: latch the winner's byte into oTX_FIFO_DATA, set rr_ptr and oGRANT_ID to the winner, clear baud_cnt and bit_cnt, go to SEND.
  - oREQ_READY is 0 in every state other than IDLE.
- SEND:
  - baud_cnt counts 0..CLKS_PER_BAUD-1 and wraps.
  - When baud_cnt==CLKS_PER_BAUD-1: oTX_BAUD_clk=1 for exactly one cycle and bit_cnt increments.
  - After the 10th strobe (start, D0..D7, stop), go to STOP.
- STOP: wait one more full bit period, i.e. CLKS_PER_BAUD cycles, for the stop-bit duration; no strobe is issued. Then go to FIN.
- FIN: oFINISH=1 for one cycle, then return to IDLE.
- Timing, with grant at edge G:
  - strobes at cycles G+k*CLKS_PER_BAUD, k=1..10
  - oFINISH at G+11*CLKS_PER_BAUD
  - IDLE at G+11*CLKS_PER_BAUD+1; a new grant is possible in that same cycle.
- oTX_FIFO_DATA and oGRANT_ID stay stable from grant until the next grant; bytes are never changed mid-frame.
- oBUSY = (state != IDLE).
- Requesters may drop iREQ_VALID at any time before acceptance without side effects. A requester whose valid is high during a frame waits; no request is lost or accepted twice.
- A valid arriving in the same cycle the FSM enters IDLE is arbitrated that cycle.
- The rr_ptr winner gets lowest priority next round: with all valid, the grant order is 0,1,2,...,NUM_REQ-1,0.
- Reset asserted mid-frame: all state returns to reset values at the next edge, with no oFINISH. The top level must reset the TX serializer from the same source (inverted for its active-low reset).

Test Plan:
- Single byte: CLKS_PER_BAUD=4; requester 2 sends 8'hA5 at cycle 10 → oREQ_READY=4'b0100 at cycle 10; strobes at cycles 14,18,...,50; oFINISH at cycle 54; the bench TX model decodes the serial line as 0,1,0,1,0,0,1,0,1,1 (start, LSB-first A5, stop).
- Round-robin fairness: all four valid continuously with bytes 8'h10..8'h13 → grant order 0,1,2,3,0; consecutive grants are exactly 11*CLKS_PER_BAUD+1 cycles apart; each byte appears once per grant.
- Withdrawn request: requester 1 raises valid mid-frame and drops it before IDLE → no oREQ_READY[1], no extra frame; oBUSY falls after oFINISH.
- Reset mid-frame: assert reset after the 5th strobe → next cycle all outputs are at reset values; no oFINISH; the first request after release goes to requester 0.
- Minimum divisor: CLKS_PER_BAUD=2; byte 8'hFF → strobes every 2 cycles (10 total); oFINISH exactly 22 cycles after grant; oTX_BAUD_clk never high for two consecutive cycles.
- Simultaneous return/request: requester 3 asserts valid in the cycle after oFINISH → granted that same cycle; oTX_FIFO_DATA updates at that edge and not earlier.
